// File: rtl/lzss_fifo_decoder.sv
// LZSS token decoder: pops 16-bit tokens from a fall-through FIFO and expands them into a byte stream.
// Optional LZSS_DEC_ERR_EN adds a sticky ERR output flagging illegal match distances.
`timescale 1ns/1ps
module lzss_fifo_decoder #(
   parameter int unsigned WIN_AW  = 11,
   parameter int unsigned MIN_LEN = 3
) (
   input  logic        CLK,
   input  logic        RSTB,
   output logic        FIFO_RD,
   input  logic [15:0] FIFO_DATA,
   input  logic        FIFO_EMPTY,
   output logic        OUT_VALID,
   output logic [7:0]  OUT_DATA,
   input  logic        OUT_READY
`ifdef LZSS_DEC_ERR_EN
   ,
   output logic        ERR
`endif
);

   localparam int unsigned WIN_DEPTH = 2 ** WIN_AW;
   localparam int unsigned LEN_W     = $clog2(15 + MIN_LEN + 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_COPY = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [WIN_AW-1:0] wptr_q, wptr_d;
   logic [WIN_AW-1:0] dist_q, dist_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic              out_valid_q, out_valid_d;
   logic [7:0]        out_data_q, out_data_d;

   logic [7:0]        hist_q [WIN_DEPTH];
   logic              hist_we;
   logic [7:0]        hist_wdata;
   logic [7:0]        copy_byte;
   logic              out_free_c;
   logic              pop_c;

`ifdef LZSS_DEC_ERR_EN
   logic              err_q, err_d;
   logic [WIN_AW:0]   wcnt_q, wcnt_d;
`endif

   assign out_free_c = ~out_valid_q | OUT_READY;
   assign pop_c      = RSTB & (state_q == ST_IDLE) & ~FIFO_EMPTY & out_free_c;
   assign FIFO_RD    = pop_c;
   assign OUT_VALID  = out_valid_q;
   assign OUT_DATA   = out_data_q;
   // The write of the previous cycle is already in the array, so distance 1 sees it
   assign copy_byte  = hist_q[wptr_q - dist_q];

   // Next-state: token decode in IDLE, byte replay in COPY
   always_comb begin
      state_d     = state_q;
      wptr_d      = wptr_q;
      dist_d      = dist_q;
      rem_d       = rem_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      hist_we     = 1'b0;
      hist_wdata  = 8'h00;
`ifdef LZSS_DEC_ERR_EN
      err_d       = err_q;
      wcnt_d      = wcnt_q;
`endif

      if (out_free_c) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (pop_c) begin
               if (FIFO_DATA[15]) begin
                  hist_we    = 1'b1;
                  hist_wdata = FIFO_DATA[7:0];
               end else begin
                  dist_d  = WIN_AW'(FIFO_DATA[14:4]);
                  rem_d   = LEN_W'(FIFO_DATA[3:0]) + LEN_W'(MIN_LEN);
                  state_d = ST_COPY;
`ifdef LZSS_DEC_ERR_EN
                  if ((dist_d == '0) || ({1'b0, dist_d} > wcnt_q)) begin
                     err_d = 1'b1;
                  end
`endif
               end
            end
         end
         ST_COPY: begin
            if (out_free_c) begin
               hist_we    = 1'b1;
               hist_wdata = copy_byte;
               rem_d      = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (hist_we) begin
         out_valid_d = 1'b1;
         out_data_d  = hist_wdata;
         wptr_d      = wptr_q + WIN_AW'(1);
`ifdef LZSS_DEC_ERR_EN
         if (wcnt_q != (WIN_AW + 1)'(WIN_DEPTH)) begin
            wcnt_d = wcnt_q + (WIN_AW + 1)'(1);
         end
`endif
      end
   end

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         state_q     <= ST_IDLE;
         wptr_q      <= '0;
         dist_q      <= '0;
         rem_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         wptr_q      <= wptr_d;
         dist_q      <= dist_d;
         rem_q       <= rem_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   // History window is deliberately not reset
   always_ff @(posedge CLK) begin
      if (hist_we) begin
         hist_q[wptr_q] <= hist_wdata;
      end
   end

`ifdef LZSS_DEC_ERR_EN
   assign ERR = err_q;

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         err_q  <= 1'b0;
         wcnt_q <= '0;
      end else begin
         err_q  <= err_d;
         wcnt_q <= wcnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_lzss_fifo_decoder.sv
// Directed bench for lzss_fifo_decoder: token FIFO model, reference expander feeding a byte scoreboard.
// ERR checks are built when LZSS_DEC_ERR_EN is defined.
`timescale 1ns/1ps
module tb_lzss_fifo_decoder;

   localparam int unsigned WIN_DEPTH = 2048;

   logic        CLK = 1'b0;
   logic        RSTB = 1'b0;
   logic        FIFO_RD;
   logic [15:0] FIFO_DATA;
   logic        FIFO_EMPTY;
   logic        OUT_VALID;
   logic [7:0]  OUT_DATA;
   logic        OUT_READY = 1'b1;
`ifdef LZSS_DEC_ERR_EN
   logic        ERR;
`endif

   logic [15:0] fmem [4096];
   int          head = 0;
   int          tail = 0;

   logic [7:0]  sb [$];
   logic [7:0]  mhist [WIN_DEPTH];
   int          mw = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   int          copy_left = 0;
   bit          prev_stall = 1'b0;
   logic [7:0]  prev_data = 8'h00;
   bit          pat_en = 1'b0;
   int          pat_idx = 0;
   int          rx_cnt = 0;

   lzss_fifo_decoder dut (
      .CLK        (CLK),
      .RSTB       (RSTB),
      .FIFO_RD    (FIFO_RD),
      .FIFO_DATA  (FIFO_DATA),
      .FIFO_EMPTY (FIFO_EMPTY),
      .OUT_VALID  (OUT_VALID),
      .OUT_DATA   (OUT_DATA),
      .OUT_READY  (OUT_READY)
`ifdef LZSS_DEC_ERR_EN
      ,
      .ERR        (ERR)
`endif
   );

   always #5 CLK = ~CLK;

   assign FIFO_EMPTY = (head == tail);
   assign FIFO_DATA  = fmem[head[11:0]];

   always @(posedge CLK) begin
      if (FIFO_RD) head <= head + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Push a token and expand it in the reference window
   task automatic push_tok(input logic [15:0] t);
      int d;
      int l;
      logic [7:0] b;
      fmem[tail[11:0]] = t;
      tail++;
      if (t[15]) begin
         sb.push_back(t[7:0]);
         mhist[11'(mw)] = t[7:0];
         mw++;
      end else begin
         d = int'(t[14:4]);
         l = int'(t[3:0]) + 3;
         for (int i = 0; i < l; i++) begin
            b = mhist[11'(mw - d)];
            sb.push_back(b);
            mhist[11'(mw)] = b;
            mw++;
         end
      end
   endtask

   task automatic monitor();
      logic [7:0] e;
      if (!RSTB) begin
         chk("rd_in_reset", 32'(FIFO_RD), 32'd0);
         chk("valid_in_reset", 32'(OUT_VALID), 32'd0);
      end else begin
         if (FIFO_EMPTY) chk("rd_when_empty", 32'(FIFO_RD), 32'd0);
         if (prev_stall) begin
            chk("stall_valid", 32'(OUT_VALID), 32'd1);
            chk("stall_data", 32'(OUT_DATA), 32'(prev_data));
         end
         if (copy_left > 0) begin
            chk("rd_in_copy", 32'(FIFO_RD), 32'd0);
            if (!OUT_VALID || OUT_READY) copy_left--;
         end else if (FIFO_RD && !FIFO_DATA[15]) begin
            copy_left = int'(FIFO_DATA[3:0]) + 3;
         end
         if (OUT_VALID && OUT_READY) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("out_byte", 32'(OUT_DATA), 32'(e));
            end
            rx_cnt++;
         end
         prev_stall = OUT_VALID && !OUT_READY;
         prev_data  = OUT_DATA;
      end
   endtask

   task automatic tick();
      @(negedge CLK);
      if (pat_en) begin
         OUT_READY = ((pat_idx % 4) == 0) || ((pat_idx % 4) == 3);
         pat_idx++;
      end
      #1;
      monitor();
   endtask

   task automatic sync_pos();
      @(posedge CLK);
      #1;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      chk("drain_done", 32'(sb.size()), 32'd0);
      pat_en = 1'b0;
      OUT_READY = 1'b1;
      repeat (3) tick();
      chk("idle_valid", 32'(OUT_VALID), 32'd0);
   endtask

   task automatic do_reset();
      RSTB = 1'b0;
      sb.delete();
      copy_left  = 0;
      prev_stall = 1'b0;
      mw = 0;
      repeat (2) tick();
      RSTB = 1'b1;
      tick();
   endtask

   initial begin
      logic [15:0] t;
      int n;

      // Reset state, and no pop while held in reset even with data present
      repeat (2) tick();
      chk("rst_valid", 32'(OUT_VALID), 32'd0);
      chk("rst_data", 32'(OUT_DATA), 32'd0);
      push_tok(16'h807A);
      #1;
      chk("rst_rd_forced", 32'(FIFO_RD), 32'd0);
      tick();
      RSTB = 1'b1;
      drain(20);

      // Back-to-back literals: 1 byte/cycle, one cycle after the pop
      sync_pos();
      push_tok(16'h8041);
      push_tok(16'h8042);
      push_tok(16'h8043);
      tick();
      chk("lit_rd0", 32'(FIFO_RD), 32'd1);
      chk("lit_v0", 32'(OUT_VALID), 32'd0);
      tick();
      chk("lit_rd1", 32'(FIFO_RD), 32'd1);
      chk("lit_d1", 32'(OUT_DATA), 32'h41);
      tick();
      chk("lit_rd2", 32'(FIFO_RD), 32'd1);
      chk("lit_d2", 32'(OUT_DATA), 32'h42);
      tick();
      chk("lit_rd3", 32'(FIFO_RD), 32'd0);
      chk("lit_d3", 32'(OUT_DATA), 32'h43);
      drain(20);

      // Distance-1 match with a one-cycle bubble after the match pop
      sync_pos();
      push_tok(16'h8061);
      push_tok(16'h0010);
      tick();
      tick();
      chk("m1_v_lit", 32'(OUT_VALID), 32'd1);
      chk("m1_rd_match", 32'(FIFO_RD), 32'd1);
      tick();
      chk("m1_bubble", 32'(OUT_VALID), 32'd0);
      tick();
      chk("m1_first_copy_v", 32'(OUT_VALID), 32'd1);
      chk("m1_first_copy_d", 32'(OUT_DATA), 32'h61);
      drain(20);

      // Overlapping copy a b c -> a b c a b c a b c
      sync_pos();
      push_tok(16'h8061);
      push_tok(16'h8062);
      push_tok(16'h8063);
      push_tok(16'h0033);
      drain(40);

      // Same stream under backpressure
      pat_en = 1'b1;
      pat_idx = 0;
      sync_pos();
      push_tok(16'h8061);
      push_tok(16'h8062);
      push_tok(16'h8063);
      push_tok(16'h0033);
      drain(80);

      // Reset during the third byte of a length-6 copy
      rx_cnt = 0;
      sync_pos();
      push_tok(16'h8078);
      push_tok(16'h8079);
      push_tok(16'h0023);
      n = 0;
      while (rx_cnt < 4 && n < 40) begin
         tick();
         n++;
      end
      chk("rx_wait", 32'(rx_cnt >= 4), 32'd1);
      @(posedge CLK);
      #2;
      chk("mid_copy_valid", 32'(OUT_VALID), 32'd1);
      chk("mid_copy_data", 32'(OUT_DATA), 32'h78);
      RSTB = 1'b0;
      #1;
      chk("arst_valid", 32'(OUT_VALID), 32'd0);
      chk("arst_data", 32'(OUT_DATA), 32'd0);
      chk("arst_rd", 32'(FIFO_RD), 32'd0);
      sb.delete();
      copy_left  = 0;
      prev_stall = 1'b0;
      mw = 0;
      repeat (2) tick();
      RSTB = 1'b1;
      sync_pos();
      push_tok(16'h8055);
      drain(20);

      // Window wrap, distance 0 (oldest byte) and maximum distance
      sync_pos();
      for (int i = 0; i < 2100; i++) begin
         t = {8'h80, 8'($urandom)};
         push_tok(t);
      end
      push_tok({1'b0, 11'd0, 4'd15});
      push_tok({1'b0, 11'd2047, 4'd5});
      push_tok({1'b0, 11'd1000, 4'd9});
      drain(3000);

`ifdef LZSS_DEC_ERR_EN
      // Distance beyond bytes written
      do_reset();
      chk("err_rst", 32'(ERR), 32'd0);
      sync_pos();
      push_tok(16'h8078);
      push_tok(16'h0050);
      tick();
      tick();
      chk("err_pre", 32'(ERR), 32'd0);
      tick();
      chk("err_set", 32'(ERR), 32'd1);
      drain(20);
      chk("err_sticky", 32'(ERR), 32'd1);

      // Legal stream keeps ERR low, then distance 0 sets it
      do_reset();
      chk("err_rst2", 32'(ERR), 32'd0);
      sync_pos();
      push_tok(16'h8061);
      push_tok(16'h8062);
      push_tok(16'h8063);
      push_tok(16'h0033);
      drain(40);
      chk("err_legal", 32'(ERR), 32'd0);
      sync_pos();
      push_tok(16'h0000);
      drain(20);
      chk("err_dist0", 32'(ERR), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lzss_fifo_decoder.md
Name: lzss_fifo_decoder

Overview:
- Consumer at the read end of the token FIFO.
- Pops 16-bit LZSS tokens from the FIFO read port, which is fall-through: read data is valid whenever the FIFO is not empty.
- Expands each token into a byte stream, using an internal history window.
- Presents the bytes on a valid/ready output for the downstream byte sink.

Parameters:
- WIN_AW, 11: history window address width. Window depth is 2^WIN_AW bytes.
- MIN_LEN, 3: match length bias. Match length = length code + MIN_LEN.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RSTB  input  1  asynchronous active-low reset.
- FIFO_RD  output  1  pop strobe to the FIFO READ port; one word is consumed per cycle while high.
- FIFO_DATA  input  16  head-of-FIFO token, combinationally valid when FIFO_EMPTY=0.
- FIFO_EMPTY  input  1  FIFO empty flag.
- OUT_VALID  output  1  output byte valid.
- OUT_DATA  output  8  output byte.
- OUT_READY  input  1  sink accepts OUT_DATA when OUT_VALID & OUT_READY.

Behaviour:
- Token format:
  - bit15=1: literal; byte = [7:0]; bits [14:8] ignored.
  - bit15=0: match; distance = [14:4] (11 bits, zero-extended or truncated to WIN_AW); length = [3:0] + MIN_LEN, i.e. 3..18 at default.
- Reset values: OUT_VALID=0, OUT_DATA=0, state=IDLE, write pointer wptr=0, copy distance=0, remaining count rem=0.
  - History RAM is not reset.
  - FIFO_RD is forced 0 while RSTB=0.
  - Reset mid-match abandons the copy; the next token is decoded from IDLE.
- Output free condition: out_free = ~OUT_VALID | OUT_READY.
- FIFO_RD (combinational) = RSTB & state==IDLE & ~FIFO_EMPTY & out_free.
  - Never asserted when FIFO_EMPTY=1.
  - Never asserted in COPY.
- State IDLE, on a pop of a literal:
  - OUT_DATA<=byte, OUT_VALID<=1.
  - hist[wptr]<=byte, wptr<=wptr+1.
  - Stay in IDLE. Back-to-back literals therefore run at 1 byte/cycle.
- State IDLE, on a pop of a match:
  - Latch distance; rem<=length; go to COPY.
  - No byte is output this cycle. If OUT_VALID was 1 and OUT_READY=1, OUT_VALID<=0.
- State COPY, each cycle with out_free:
  - b = hist[(wptr - distance) mod 2^WIN_AW], read combinationally.
  - OUT_DATA<=b, OUT_VALID<=1, hist[wptr]<=b, wptr<=wptr+1, rem<=rem-1.
  - When rem==1, return to IDLE.
  - Cycles without out_free: hold all state.
- Overlapping copies (distance < length) must replicate correctly. Distance 1 repeats the last byte; the byte written in the previous cycle must be readable in the current cycle.
- Latency: pop of a literal at edge N gives OUT_VALID at N+1. Pop of a match at edge N gives the first copy byte at N+2. A match of L bytes occupies L+1 cycles with no backpressure.
- Output handshake:
  - OUT_DATA and OUT_VALID stay stable while OUT_VALID=1 & OUT_READY=0.
  - When OUT_READY=1 and no new byte is produced that cycle, OUT_VALID<=0 on the next edge.
- wptr wraps modulo 2^WIN_AW.
- distance=0 indexes hist[wptr], which is the oldest window byte: output is stale data, and the byte count is still correct.
- No flush or last marker. The block is idle when state=IDLE, OUT_VALID=0 and FIFO_EMPTY=1.

Optional Feature:
- Macro: LZSS_DEC_ERR_EN.
- When defined:
  - Adds output port ERR (1 bit), reset 0.
  - Adds a saturating count of bytes written, capped at 2^WIN_AW.
  - ERR is set to 1 on the cycle after popping a match with distance==0 or distance > bytes written.
  - ERR is sticky until reset. Decoding continues unchanged.
- When undefined: no ERR port and no counter. Illegal distances decode as described above with no indication.

Test Plan:
- Literals 0x8041, 0x8042, 0x8043 preloaded, OUT_READY=1 → FIFO_RD high 3 consecutive cycles; OUT_DATA 0x41,0x42,0x43 on consecutive cycles, first one cycle after the first pop.
- Literal 0x8061 then match 0x0010 (distance 1, code 0, length 3) → output 0x61,0x61,0x61,0x61; one-cycle bubble after the match pop.
- Literals 'a','b','c' then match 0x0033 (distance 3, length 6) → a b c a b c a b c.
- Same stream with OUT_READY toggled 1,0,0,1 repeating → identical byte sequence with none dropped or duplicated; OUT_DATA stable during stalls; FIFO_RD never high in COPY or when FIFO_EMPTY=1.
- RSTB pulsed low during the 3rd byte of a length-6 copy → OUT_VALID=0 immediately. After release, literal 0x8055 outputs 0x55; the remaining copy bytes are never emitted.
- With LZSS_DEC_ERR_EN: literal 'x' then match 0x0050 (distance 5 > 1 written) → ERR=1 and remains 1. A separate run with match distance 0 also sets ERR. A legal stream leaves ERR=0.
